mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned STARVE_MAX_DEF = 3;
   localparam int unsigned CNT_W          = 3;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (IF) and data (DM) ports onto one single-port synchronous RAM,
// DM first by default, with IF taking priority after STARVE_MAX denied cycles.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
   parameter int unsigned AW         = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          cancel,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          dm_req,
   input  logic [3:0]    dm_wen,
   input  logic [31:0]   dm_addr,
   input  logic [31:0]   dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [31:0]   dm_rdata,
   output logic [3:0]    ram_wen,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata,
   output logic          starved
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   owner_e           resp_owner, owner_nxt;
   logic [AW-1:0]    last_addr, addr_nxt;
   logic             if_prio;

   // Byte-offset and high address bits never reach the word-addressed RAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0],
                               dm_addr[31:AW+2], dm_addr[1:0]};

   // State register: owner of next-cycle read data, starvation count, held address.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         resp_owner <= OWN_NONE;
         starve_cnt <= '0;
         last_addr  <= '0;
      end else begin
         resp_owner <= owner_nxt;
         starve_cnt <= starve_nxt;
         last_addr  <= addr_nxt;
      end
   end

   // Grant selection, RAM drive and next-state logic.
   always_comb begin
      if_gnt     = 1'b0;
      dm_gnt     = 1'b0;
      ram_wen    = 4'b0;
      ram_addr   = '0;
      ram_wdata  = 32'b0;
      owner_nxt  = OWN_NONE;
      starve_nxt = starve_cnt;
      addr_nxt   = last_addr;
      if_prio    = (starve_cnt == STARVE_LIM) && if_req && !cancel;

      if (resetn) begin
         if (if_req && !cancel && (if_prio || !dm_req))
            if_gnt = 1'b1;
         else if (dm_req)
            dm_gnt = 1'b1;
      end

      if (if_gnt) begin
         addr_nxt  = if_addr[AW+1:2];
         owner_nxt = OWN_IF;
      end else if (dm_gnt) begin
         addr_nxt = dm_addr[AW+1:2];
         ram_wen  = dm_wen;
         if (dm_wen == 4'b0)
            owner_nxt = OWN_DM;
      end

      if (resetn) begin
         ram_addr  = addr_nxt;
         ram_wdata = dm_wdata;
      end

      // A denied fetch ages toward priority; a grant or flush restarts the count.
      if (cancel || if_gnt)
         starve_nxt = '0;
      else if (if_req && (starve_cnt != STARVE_LIM))
         starve_nxt = starve_cnt + CNT_W'(1);
   end

   // Read data is steered to the port that owned last cycle's read; a flush kills fetch data.
   always_comb begin
      if_rvalid = resetn && (resp_owner == OWN_IF) && !cancel;
      dm_rvalid = resetn && (resp_owner == OWN_DM);
      if_rdata  = if_rvalid ? ram_rdata : 32'b0;
      dm_rdata  = dm_rvalid ? ram_rdata : 32'b0;
      starved   = (starve_cnt == STARVE_LIM);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          cancel;
   logic          if_req;
   logic [31:0]   if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;
   logic          dm_req;
   logic [3:0]    dm_wen;
   logic [31:0]   dm_addr;
   logic [31:0]   dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [31:0]   dm_rdata;
   logic [3:0]    ram_wen;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic          starved;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:(1<<AW)-1];

   mem_port_arbiter #(.STARVE_MAX(3), .AW(AW)) dut (
      .clk(clk), .resetn(resetn), .cancel(cancel),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .starved(starved)
   );

   always #5 clk = ~clk;

   // Single-port RAM: byte writes, read data one cycle after the address.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 1'b0; dm_req = 1'b0; dm_wen = 4'b0; cancel = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + i;
      mem[4] = 32'hDEAD_BEEF;
      mem[8] = 32'hFFFF_FFFF;

      resetn = 1'b0; cancel = 1'b0;
      if_req = 1'b1; if_addr = 32'h4;
      dm_req = 1'b1; dm_wen = 4'b0; dm_addr = 32'h10; dm_wdata = 32'h0;
      ram_rdata = 32'h0;
      #1;
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wen", 32'(ram_wen), 32'd0);
      cyc(); cyc();
      chk("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      chk("rst_starved", 32'(starved), 32'd0);

      resetn = 1'b1; idle();
      #1;
      chk("idle_gnt", 32'({if_gnt, dm_gnt}), 32'd0);
      cyc();

      // Single DM read of word 4
      dm_req = 1'b1; dm_addr = 32'h10; #1;
      chk("rd_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("rd_ram_addr", 32'(ram_addr), 32'd4);
      cyc();
      idle(); #1;
      chk("rd_dm_rvalid", 32'(dm_rvalid), 32'd1);
      chk("rd_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      chk("rd_if_quiet", 32'(if_rvalid) | if_rdata, 32'd0);
      chk("rd_addr_hold", 32'(ram_addr), 32'd4);
      cyc();

      // Collision: DM,DM,DM then IF on the 4th cycle
      if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_addr = 32'h10; #1;
      chk("col1_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      chk("col1_starved", 32'(starved), 32'd0);
      cyc();
      chk("col2_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      chk("col2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      cyc();
      chk("col3_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      cyc();
      chk("col4_gnt", 32'({if_gnt, dm_gnt}), 32'b10);
      chk("col4_starved", 32'(starved), 32'd1);
      chk("col4_ram_addr", 32'(ram_addr), 32'd0);
      cyc();
      chk("col5_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      chk("col5_starved", 32'(starved), 32'd0);
      chk("col5_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("col5_if_rdata", if_rdata, 32'hA000_0000);
      chk("col5_dm_quiet", 32'(dm_rvalid) | dm_rdata, 32'd0);
      cyc();
      idle(); #1;
      chk("col6_dm_rvalid", 32'(dm_rvalid), 32'd1);
      cyc();

      // Partial write then read back word 8
      dm_req = 1'b1; dm_wen = 4'b0011; dm_wdata = 32'h1234_5678; dm_addr = 32'h20; #1;
      chk("wr_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("wr_ram_wen", 32'(ram_wen), 32'h3);
      chk("wr_ram_addr", 32'(ram_addr), 32'd8);
      cyc();
      dm_wen = 4'b0; #1;
      chk("wr_no_rvalid", 32'(dm_rvalid), 32'd0);
      chk("wr_rd_ram_wen", 32'(ram_wen), 32'd0);
      cyc();
      idle(); #1;
      chk("wr_rd_rvalid", 32'(dm_rvalid), 32'd1);
      chk("wr_rd_rdata", dm_rdata, 32'hFFFF_5678);
      cyc();

      // Cancel kills an in-flight fetch response
      if_req = 1'b1; if_addr = 32'h4; #1;
      chk("can_if_gnt", 32'(if_gnt), 32'd1);
      cyc();
      cancel = 1'b1; #1;
      chk("can_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("can_if_rdata", if_rdata, 32'd0);
      chk("can_if_gnt_off", 32'(if_gnt), 32'd0);
      cyc();
      // Age the count to 2, then a cancel must clear it
      cancel = 1'b0; dm_req = 1'b1; dm_addr = 32'h10;
      cyc(); cyc();
      cancel = 1'b1; #1;
      chk("can_dm_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      cyc();
      cancel = 1'b0; #1;
      chk("can_cnt0_starved", 32'(starved), 32'd0);
      chk("can_c1_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      cyc();
      chk("can_c2_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      cyc();
      chk("can_c3_gnt", 32'({if_gnt, dm_gnt}), 32'b01);
      cyc();
      chk("can_c4_gnt", 32'({if_gnt, dm_gnt}), 32'b10);
      cyc();
      idle(); cyc();

      // Reset while a DM read is outstanding; low address bits ignored
      dm_req = 1'b1; dm_addr = 32'h13; #1;
      chk("rr_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("rr_ram_addr", 32'(ram_addr), 32'd4);
      cyc();
      idle(); resetn = 1'b0; #1;
      chk("rr_rvalid_t1", 32'(dm_rvalid), 32'd0);
      chk("rr_rdata_t1", dm_rdata, 32'd0);
      cyc();
      resetn = 1'b1; #1;
      chk("rr_rvalid_t2", 32'(dm_rvalid), 32'd0);
      cyc();

      // IF streaming: four back-to-back reads, words 0..3
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            if_req = 1'b1; if_addr = 32'(4*i);
         end else begin
            if_req = 1'b0;
         end
         #1;
         if (i < 4) chk($sformatf("st%0d_if_gnt", i), 32'(if_gnt), 32'd1);
         if (i > 0) begin
            chk($sformatf("st%0d_if_rvalid", i), 32'(if_rvalid), 32'd1);
            chk($sformatf("st%0d_if_rdata", i), if_rdata, 32'hA000_0000 + 32'(i-1));
         end
         cyc();
      end
      #1;
      chk("st_end_rvalid", 32'(if_rvalid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
